// File: rtl/msg_serializer_704x32_pkg.sv
// Shared definitions for the 704-bit message serializer and its matching
// deserializer: word geometry, header layout, FSM states and message layout.
package msg_serializer_704x32_pkg;

    localparam int WIDTH     = 32;
    localparam int NWORDS    = 22;
    localparam int METHOD_ID = 5;
    localparam int MSG_W     = NWORDS * WIDTH;
    localparam int IDX_W     = $clog2(NWORDS);

    // Header word layout: length (header + data words) in the upper half,
    // method identifier in the lower half.
    localparam int HDR_FIELD_W    = 16;
    localparam int HDR_LEN_LSB    = 16;
    localparam int HDR_METHOD_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Packed so that field a occupies the least significant word.
    typedef struct packed {
        logic [NWORDS-3:0][WIDTH-1:0] c;
        logic [WIDTH-1:0]             b;
        logic [WIDTH-1:0]             a;
    } msg_t;

    function automatic logic [WIDTH-1:0] make_header(
        input logic [HDR_FIELD_W-1:0] len,
        input logic [HDR_FIELD_W-1:0] method
    );
        logic [WIDTH-1:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_LSB    +: HDR_FIELD_W] = len;
        hdr[HDR_METHOD_LSB +: HDR_FIELD_W] = method;
        return hdr;
    endfunction

endpackage

// File: rtl/msg_word_mux.sv
// Selects one 32-bit word out of a 704-bit message by word index.
// Indices beyond the last word yield zero.
module msg_word_mux
    import msg_serializer_704x32_pkg::*;
(
    input  logic [MSG_W-1:0] msg,
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] words [NWORDS];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_split
            assign words[gi] = msg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // One-hot compare keeps the select fully defined for unreachable indices.
    always_comb begin
        word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                word = words[i];
            end
        end
    end

endmodule

// File: rtl/msg_serializer_704x32.sv
// Drains a 704-bit one-entry FIFO and emits each message as a header word
// followed by 22 data words on a 32-bit enq-style link. The message is copied
// into a shadow register at dequeue so the FIFO can refill meanwhile.
module msg_serializer_704x32
    import msg_serializer_704x32_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [MSG_W-1:0]  in_first,
    input  logic              in_first_rdy,
    output logic              in_deq_ena,
    output logic [WIDTH-1:0]  out_enq_v,
    output logic              out_enq_ena,
    input  logic              out_enq_rdy,
    output logic              busy,
    output logic [15:0]       msg_count
);

    localparam logic [WIDTH-1:0] HEADER   = make_header(HDR_FIELD_W'(NWORDS + 1),
                                                        HDR_FIELD_W'(METHOD_ID));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;
    msg_t              shadow_reg;
    logic [15:0]       msg_count_reg;
    logic              count_inc;
    logic [WIDTH-1:0]  data_word;

    msg_word_mux u_word_mux (
        .msg  (shadow_reg),
        .idx  (idx_reg),
        .word (data_word)
    );

    // Next-state, dequeue strobe and output word selection.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        in_deq_ena  = 1'b0;
        count_inc   = 1'b0;
        out_enq_v   = '0;
        busy        = (state_reg != IDLE);
        out_enq_ena = (state_reg != IDLE) && out_enq_rdy;
        case (state_reg)
            IDLE: begin
                if (in_first_rdy) begin
                    in_deq_ena = 1'b1;
                    idx_next   = '0;
                    state_next = HDR;
                end
            end
            HDR: begin
                out_enq_v = HEADER;
                if (out_enq_ena) begin
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                out_enq_v = data_word;
                if (out_enq_ena) begin
                    if (idx_reg == LAST_IDX) begin
                        // Last beat: chain straight into the next message if one waits.
                        count_inc = 1'b1;
                        idx_next  = '0;
                        if (in_first_rdy) begin
                            in_deq_ena = 1'b1;
                            state_next = HDR;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Beat index, shadow copy of the dequeued message and completed-message count.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            idx_reg       <= '0;
            shadow_reg    <= '0;
            msg_count_reg <= '0;
        end else begin
            idx_reg <= idx_next;
            if (in_deq_ena) begin
                shadow_reg <= in_first;
            end
            if (count_inc) begin
                msg_count_reg <= msg_count_reg + 16'd1;
            end
        end
    end

    assign msg_count = msg_count_reg;

endmodule

// File: tb/tb_msg_serializer_704x32.sv
// Self-checking bench for msg_serializer_704x32: directed table-driven
// sequences plus randomized traffic checked against a queue-based model.
module tb_msg_serializer_704x32;

    localparam logic [31:0] HDR_WORD = 32'h0017_0005;

    logic         CLK;
    logic         nRST;
    logic [703:0] in_first;
    logic         in_first_rdy;
    logic         in_deq_ena;
    logic [31:0]  out_enq_v;
    logic         out_enq_ena;
    logic         out_enq_rdy;
    logic         busy;
    logic [15:0]  msg_count;

    msg_serializer_704x32 dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_first     (in_first),
        .in_first_rdy (in_first_rdy),
        .in_deq_ena   (in_deq_ena),
        .out_enq_v    (out_enq_v),
        .out_enq_ena  (out_enq_ena),
        .out_enq_rdy  (out_enq_rdy),
        .busy         (busy),
        .msg_count    (msg_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          rdy;
        bit          ena;
        logic [31:0] v;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: pending FIFO contents and expected output word stream.
    logic [703:0] fifo_q [$];
    logic [31:0]  exp_q [$];
    logic [15:0]  exp_count = 16'd0;
    int           beats     = 0;
    bit           allow     = 1'b1;

    // Values sampled from the DUT at the falling edge of the last tick.
    logic         s_deq, s_ena, s_busy;
    logic [31:0]  s_v;
    logic [15:0]  s_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        in_first_rdy = allow && (fifo_q.size() > 0);
        in_first     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    function automatic logic [31:0] msg1_word(input int k);
        if (k == 0) return HDR_WORD;
        if (k == 1) return 32'h1111_1111;
        if (k == 2) return 32'h2222_2222;
        return 32'hC000_0000 + 32'(k - 3);
    endfunction

    function automatic logic [703:0] make_msg1();
        logic [703:0] m;
        for (int k = 0; k < 22; k++) m[32*k +: 32] = msg1_word(k + 1);
        return m;
    endfunction

    function automatic logic [703:0] rand_msg();
        logic [703:0] m;
        for (int k = 0; k < 22; k++) m[32*k +: 32] = $urandom;
        return m;
    endfunction

    // One clock: sample/check at negedge, advance model at posedge, drive at +1.
    task automatic tick();
        logic exp_busy, exp_deq;
        logic [703:0] m;
        @(negedge CLK);
        s_deq = in_deq_ena; s_ena = out_enq_ena; s_v = out_enq_v;
        s_busy = busy; s_count = msg_count;
        if (nRST) begin
            exp_busy = (exp_q.size() != 0);
            exp_deq  = in_first_rdy && (exp_q.size() == 0 ||
                                        (exp_q.size() == 1 && out_enq_rdy));
            check("busy", 32'(s_busy), 32'(exp_busy));
            check("enq_ena", 32'(s_ena), 32'(exp_busy && out_enq_rdy));
            check("deq_ena", 32'(s_deq), 32'(exp_deq));
            check("msg_count", 32'(s_count), 32'(exp_count));
            if (exp_busy) begin
                check("enq_v", s_v, exp_q[0]);
                if (out_enq_rdy) begin
                    void'(exp_q.pop_front());
                    beats++;
                    if (beats % 23 == 0) exp_count = exp_count + 16'd1;
                end
            end else begin
                check("idle_v", s_v, 32'h0);
            end
        end
        @(posedge CLK);
        if (!nRST) begin
            exp_q.delete();
            exp_count = 16'd0;
            beats     = 0;
        end else if (s_deq && fifo_q.size() > 0) begin
            m = fifo_q.pop_front();
            exp_q.push_back(HDR_WORD);
            for (int k = 0; k < 22; k++) exp_q.push_back(m[32*k +: 32]);
        end
        #1;
        drive();
    endtask

    task automatic run_table(input vec_t tbl [$], input string name);
        int deqs;
        deqs = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            out_enq_rdy = tbl[i].rdy;
            tick();
            check({name, "_ena"}, 32'(s_ena), 32'(tbl[i].ena));
            check({name, "_v"}, s_v, tbl[i].v);
            if (s_deq) deqs++;
        end
        check({name, "_extra_deq"}, 32'(deqs), 32'd0);
    endtask

    initial begin
        vec_t tbl [$];
        int   n, budget;

        nRST = 1'b0; allow = 1'b0; out_enq_rdy = 1'b0;
        drive();
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ena", 32'(out_enq_ena), 32'd0);
        check("rst_v", out_enq_v, 32'd0);
        check("rst_count", 32'(msg_count), 32'd0);
        check("rst_deq", 32'(in_deq_ena), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Single message, continuous ready.
        allow = 1'b1; out_enq_rdy = 1'b1;
        fifo_q.push_back(make_msg1());
        drive();
        tick();
        check("t1_deq", 32'(s_deq), 32'd1);
        tbl.delete();
        for (int k = 0; k < 23; k++) tbl.push_back('{1'b1, 1'b1, msg1_word(k)});
        run_table(tbl, "t1");
        tick();
        check("t1_count", 32'(s_count), 32'd1);
        check("t1_idle", 32'(s_busy), 32'd0);

        // Backpressure on data beat 5 (stream beat 6): ready low twice, word held.
        fifo_q.push_back(make_msg1());
        drive();
        tick();
        check("t2_deq", 32'(s_deq), 32'd1);
        tbl.delete();
        for (int k = 0; k < 6; k++) tbl.push_back('{1'b1, 1'b1, msg1_word(k)});
        tbl.push_back('{1'b0, 1'b0, msg1_word(6)});
        tbl.push_back('{1'b0, 1'b0, msg1_word(6)});
        for (int k = 6; k < 23; k++) tbl.push_back('{1'b1, 1'b1, msg1_word(k)});
        run_table(tbl, "t2");
        tick();
        check("t2_count", 32'(s_count), 32'd2);

        // Back-to-back: two messages queued, no bubble between them.
        fifo_q.push_back(rand_msg());
        fifo_q.push_back(rand_msg());
        out_enq_rdy = 1'b1;
        drive();
        tick();
        n = 0;
        for (int i = 0; i < 46; i++) begin
            tick();
            if (s_ena) n++;
            if (i == 22) check("t3_last_beat_deq", 32'(s_deq), 32'd1);
            if (i == 23) check("t3_hdr2", s_v, HDR_WORD);
        end
        check("t3_beats", 32'(n), 32'd46);
        tick();
        check("t3_count", 32'(s_count), 32'd4);

        // Reset after ten beats of a message.
        fifo_q.push_back(rand_msg());
        drive();
        tick();
        n = 0;
        budget = 0;
        while (n < 10 && budget < 100) begin
            tick();
            if (s_ena) n++;
            budget++;
        end
        check("t4_reached_beat10", 32'(n), 32'd10);
        nRST = 1'b0; allow = 1'b0;
        drive();
        tick();
        nRST = 1'b1;
        tick();
        check("t4_busy", 32'(s_busy), 32'd0);
        check("t4_ena", 32'(s_ena), 32'd0);
        check("t4_count", 32'(s_count), 32'd0);
        allow = 1'b1;
        fifo_q.push_back(rand_msg());
        drive();
        tick();
        tick();
        check("t4_restart_hdr", s_v, HDR_WORD);
        repeat (23) tick();
        check("t4_count_after", 32'(s_count), 32'd1);

        // Idle with empty FIFO.
        allow = 1'b0;
        drive();
        for (int i = 0; i < 50; i++) begin
            out_enq_rdy = $urandom_range(0, 1);
            tick();
            check("t5_deq", 32'(s_deq), 32'd0);
            check("t5_ena", 32'(s_ena), 32'd0);
            check("t5_v", s_v, 32'd0);
        end

        // Randomized traffic with random FIFO availability and backpressure.
        for (int i = 0; i < 150; i++) fifo_q.push_back(rand_msg());
        budget = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && budget < 20000) begin
            allow       = ($urandom_range(0, 2) != 0);
            out_enq_rdy = ($urandom_range(0, 3) != 0);
            drive();
            tick();
            budget++;
        end
        check("t6_drained", 32'(budget < 20000), 32'd1);
        out_enq_rdy = 1'b1;
        tick();
        check("t6_count", 32'(s_count), 32'd151);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
